// File: rtl/seg7_display_ctrl.sv
// N-digit seven-segment controller: valid/ready update, leading-zero blanking,
// per-digit blink, frame-aligned (tear-free) commit and optional multiplexed scan.
module seg7_display_ctrl #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BLINK_DIV  = 25000000,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      data_valid_i,
    output logic                      data_ready_o,
    input  logic [4*NUM_DIGITS-1:0]   data_i,
    input  logic                      blank_lz_i,
    input  logic [NUM_DIGITS-1:0]     blink_mask_i,
    input  logic                      scan_en_i,
    output logic [7*NUM_DIGITS-1:0]   seg_o,
    output logic [6:0]                scan_seg_o,
    output logic [NUM_DIGITS-1:0]     scan_an_o
);

    localparam int unsigned BlinkW = $clog2(BLINK_DIV);
    localparam int unsigned ScanW  = $clog2(SCAN_DIV);
    localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [BlinkW-1:0]       BlinkLast = BlinkW'(BLINK_DIV - 1);
    localparam logic [ScanW-1:0]        ScanLast  = ScanW'(SCAN_DIV - 1);
    localparam logic [IdxW-1:0]         IdxLast   = IdxW'(NUM_DIGITS - 1);
    localparam logic [6:0]              OffSeg    = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0]   OffAn     = ACTIVE_LOW ? '1 : '0;
    localparam logic [7*NUM_DIGITS-1:0] OffAll    = {NUM_DIGITS{OffSeg}};

    localparam logic StIdle = 1'b0;
    localparam logic StPend = 1'b1;

    logic                    state_q, state_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    shadow_lz_q, shadow_lz_d;
    logic [NUM_DIGITS-1:0]   shadow_mask_q, shadow_mask_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic                    disp_lz_q, disp_lz_d;
    logic [NUM_DIGITS-1:0]   disp_mask_q, disp_mask_d;
    logic [BlinkW-1:0]       blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [ScanW-1:0]        scan_cnt_q, scan_cnt_d;
    logic [IdxW-1:0]         scan_idx_q, scan_idx_d;
    logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
    logic [6:0]              scan_seg_q, scan_seg_d;
    logic [NUM_DIGITS-1:0]   scan_an_q, scan_an_d;

    logic                    scan_wrap;
    logic                    frame_end;
    logic                    commit;
    logic [7*NUM_DIGITS-1:0] seg_fin;
    logic                    lead;
    logic [3:0]              nib;
    logic [6:0]              code;
    logic [NUM_DIGITS-1:0]   onehot;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

    assign scan_wrap = scan_en_i && (scan_cnt_q == ScanLast);
    assign frame_end = scan_wrap && (scan_idx_q == IdxLast);

    // Handshake and commit; in scan mode the commit waits for the frame boundary.
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        shadow_lz_d   = shadow_lz_q;
        shadow_mask_d = shadow_mask_q;
        commit        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (data_valid_i) begin
                    shadow_d      = data_i;
                    shadow_lz_d   = blank_lz_i;
                    shadow_mask_d = blink_mask_i;
                    state_d       = StPend;
                end
            end
            StPend: begin
                if (!scan_en_i || frame_end) begin
                    commit  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        disp_d      = commit ? shadow_q : disp_q;
        disp_lz_d   = commit ? shadow_lz_q : disp_lz_q;
        disp_mask_d = commit ? shadow_mask_q : disp_mask_q;
    end

    always_comb begin
        blink_cnt_d   = (blink_cnt_q == BlinkLast) ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q ^ (blink_cnt_q == BlinkLast);
        scan_cnt_d    = '0;
        scan_idx_d    = '0;
        if (scan_en_i) begin
            if (scan_wrap) begin
                scan_idx_d = frame_end ? '0 : scan_idx_q + 1'b1;
            end else begin
                scan_cnt_d = scan_cnt_q + 1'b1;
                scan_idx_d = scan_idx_q;
            end
        end
    end

    // Final per-digit segments: decode, then blank leading zeros, then blink.
    always_comb begin
        seg_fin = '0;
        lead    = 1'b1;
        nib     = '0;
        code    = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            nib  = disp_q[4*k +: 4];
            code = hex_to_seg(nib);
            if (nib != 4'h0) begin
                lead = 1'b0;
            end
            if (disp_lz_q && lead && (k != 0)) begin
                code = '0;
            end
            if (blink_phase_q && disp_mask_q[k]) begin
                code = '0;
            end
            seg_fin[7*k +: 7] = ACTIVE_LOW ? ~code : code;
        end
    end

    always_comb begin
        onehot = NUM_DIGITS'(1) << scan_idx_q;
        seg_d  = seg_fin;
        if (scan_en_i) begin
            scan_seg_d = seg_fin[7*scan_idx_q +: 7];
            scan_an_d  = ACTIVE_LOW ? ~onehot : onehot;
        end else begin
            scan_seg_d = OffSeg;
            scan_an_d  = OffAn;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            shadow_q      <= '0;
            shadow_lz_q   <= 1'b0;
            shadow_mask_q <= '0;
            disp_q        <= '0;
            disp_lz_q     <= 1'b0;
            disp_mask_q   <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            scan_cnt_q    <= '0;
            scan_idx_q    <= '0;
            seg_q         <= OffAll;
            scan_seg_q    <= OffSeg;
            scan_an_q     <= OffAn;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            shadow_lz_q   <= shadow_lz_d;
            shadow_mask_q <= shadow_mask_d;
            disp_q        <= disp_d;
            disp_lz_q     <= disp_lz_d;
            disp_mask_q   <= disp_mask_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            scan_cnt_q    <= scan_cnt_d;
            scan_idx_q    <= scan_idx_d;
            seg_q         <= seg_d;
            scan_seg_q    <= scan_seg_d;
            scan_an_q     <= scan_an_d;
        end
    end

    assign data_ready_o = (state_q == StIdle);
    assign seg_o        = seg_q;
    assign scan_seg_o   = scan_seg_q;
    assign scan_an_o    = scan_an_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench: an 8-digit static/blink instance and a 4-digit scan instance.
module tb_seg7_display_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    // Instance A: 8 digits, fast blink.
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [31:0] a_data = '0;
    logic        a_lz = 1'b0;
    logic [7:0]  a_mask = '0;
    logic        a_scan = 1'b0;
    logic [55:0] a_seg;
    logic [6:0]  a_sseg;
    logic [7:0]  a_an;

    // Instance B: 4 digits, fast scan.
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [15:0] b_data = '0;
    logic        b_lz = 1'b0;
    logic [3:0]  b_mask = '0;
    logic        b_scan = 1'b0;
    logic [27:0] b_seg;
    logic [6:0]  b_sseg;
    logic [3:0]  b_an;

    logic [3:0]  an_exp;
    logic [15:0] word;
    int          idx;

    always #5 clk = ~clk;

    seg7_display_ctrl #(
        .NUM_DIGITS(8), .BLINK_DIV(4), .SCAN_DIV(50000), .ACTIVE_LOW(1'b1)
    ) u_a (
        .clk_i(clk), .rst_ni(rst_n), .data_valid_i(a_valid), .data_ready_o(a_ready),
        .data_i(a_data), .blank_lz_i(a_lz), .blink_mask_i(a_mask), .scan_en_i(a_scan),
        .seg_o(a_seg), .scan_seg_o(a_sseg), .scan_an_o(a_an)
    );

    seg7_display_ctrl #(
        .NUM_DIGITS(4), .BLINK_DIV(1000), .SCAN_DIV(3), .ACTIVE_LOW(1'b1)
    ) u_b (
        .clk_i(clk), .rst_ni(rst_n), .data_valid_i(b_valid), .data_ready_o(b_ready),
        .data_i(b_data), .blank_lz_i(b_lz), .blink_mask_i(b_mask), .scan_en_i(b_scan),
        .seg_o(b_seg), .scan_seg_o(b_sseg), .scan_an_o(b_an)
    );

    // Active-low codes, hand-inverted from the gfedcba table.
    function automatic logic [6:0] lo(input logic [3:0] h);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[h];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] d, input logic lz, input logic [7:0] m);
        a_data  = d;
        a_lz    = lz;
        a_mask  = m;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_a_seg", a_seg, {56{1'b1}});
        chk("rst_a_sseg", a_sseg, 7'h7F);
        chk("rst_a_an", a_an, 8'hFF);
        chk("rst_a_ready", a_ready, 1'b1);
        chk("rst_b_seg", b_seg, {28{1'b1}});
        chk("rst_b_an", b_an, 4'hF);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Plain decode, one PENDING cycle, 2-cycle latency to seg_o
        a_data  = 32'h0000_12AF;
        a_valid = 1'b1;
        tick();
        chk("t1_ready_low", a_ready, 1'b0);
        a_valid = 1'b0;
        tick();
        chk("t1_ready_back", a_ready, 1'b1);
        chk("t1_seg_old", a_seg, {8{7'h40}});
        tick();
        chk("t1_seg_new", a_seg, {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h08, 7'h0E});

        // Leading-zero blanking
        send_a(32'h0000_12AF, 1'b1, 8'h00);
        chk("t2_lz_12af", a_seg, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h08, 7'h0E});
        send_a(32'h0000_0000, 1'b1, 8'h00);
        chk("t2_lz_zero", a_seg, {{7{7'h7F}}, 7'h40});
        send_a(32'h0000_0100, 1'b1, 8'h00);
        chk("t2_lz_inner", a_seg, {{5{7'h7F}}, 7'h79, 7'h40, 7'h40});

        // Reset while PENDING: immediate OFF, shadow discarded
        a_data  = 32'h1234_5678;
        a_lz    = 1'b0;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("t6_pending", a_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_async_seg", a_seg, {56{1'b1}});
        chk("t6_async_ready", a_ready, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("t6_no_shadow", a_seg, {8{7'h40}});

        // Blink with valid held across reset release
        rst_n   = 1'b0;
        a_data  = 32'h0000_0008;
        a_mask  = 8'h01;
        a_lz    = 1'b0;
        a_valid = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n == 1) begin
                chk("t3_accept", a_ready, 1'b0);
                a_valid = 1'b0;
            end
            if (n >= 3) begin
                chk("t3_blink", a_seg,
                    {{7{7'h40}}, ((((n - 1) / 4) % 2) == 1) ? 7'h7F : 7'h00});
            end
        end

        // Scan instance: load statically first
        b_data  = 16'h1234;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        chk("t4_b_pend", b_ready, 1'b0);
        tick();
        tick();
        chk("t4_b_static", b_seg, {7'h79, 7'h24, 7'h30, 7'h19});
        chk("t4_b_an_off", b_an, 4'hF);
        chk("t4_b_sseg_off", b_sseg, 7'h7F);

        // Scan sequence with a mid-frame update (accepted while index=1)
        b_scan = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            idx    = ((n - 1) / 3) % 4;
            word   = (n >= 25) ? 16'h5678 : 16'h1234;
            an_exp = ~(4'b0001 << idx);
            chk("t4_scan_an", b_an, an_exp);
            chk("t4_scan_seg", b_sseg, lo(word[4*idx +: 4]));
            chk("t5_ready", b_ready, !(n >= 16 && n <= 23));
            if (n == 24) chk("t5_seg_old", b_seg, {7'h79, 7'h24, 7'h30, 7'h19});
            if (n == 25) chk("t5_seg_new", b_seg, {7'h12, 7'h02, 7'h78, 7'h00});
            if (n == 15) begin
                b_data  = 16'h5678;
                b_valid = 1'b1;
            end
            if (n == 16) b_valid = 1'b0;
        end
        b_scan = 1'b0;
        tick();
        chk("t4_scan_off_an", b_an, 4'hF);
        chk("t4_scan_off_seg", b_sseg, 7'h7F);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
- Parametrised N-digit seven-segment display controller; successor to the fixed 8-instance hex decode on the board top level.
- Takes a packed hex word from the processor output port through a valid/ready handshake.
- Adds the following to plain hex decode: leading-zero blanking, per-digit blinking, tear-free update, and an optional time-multiplexed scan output for boards with shared segment lines.
- Sits between the processor's data_out and the HEX/GPIO pins.

Parameters:
- NUM_DIGITS, 8: number of digits; legal range 1..16.
- BLINK_DIV, 25000000: clock cycles per blink half-period; must be >= 2.
- SCAN_DIV, 50000: clock cycles each digit stays lit in scan mode; must be >= 2.
- ACTIVE_LOW, 1: 1 means a segment or anode is ON when driven 0; 0 means ON when driven 1.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- data_valid_i  in  1  update request.
- data_ready_o  out  1  controller can accept an update.
- data_i  in  4*NUM_DIGITS  hex nibbles; digit k = data_i[4k+3:4k], digit 0 is rightmost.
- blank_lz_i  in  1  enable leading-zero blanking; sampled with data.
- blink_mask_i  in  NUM_DIGITS  bit k=1 makes digit k blink; sampled with data.
- scan_en_i  in  1  1 = scan mode active.
- seg_o  out  7*NUM_DIGITS  static per-digit segments; digit k = seg_o[7k+6:7k].
- scan_seg_o  out  7  shared segment bus in scan mode.
- scan_an_o  out  NUM_DIGITS  one-hot digit enable in scan mode.

Behaviour:

Reset (asynchronous, rst_ni=0):
- Display, shadow and mask registers cleared; blank_lz register cleared.
- Blink counter and phase = 0; scan counter and index = 0; FSM = IDLE.
- data_ready_o = 1.
- seg_o, scan_seg_o, scan_an_o all at the OFF level (all 1s when ACTIVE_LOW=1).
- Any pending update is discarded.

Segment encoding:
- Bit order gfedcba, bit0 = a. Active-high codes shown below; invert them when ACTIVE_LOW=1.
- 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.

Handshake FSM:
- IDLE: data_ready_o=1. On data_valid_i=1, capture data_i, blank_lz_i and blink_mask_i into the shadow registers, then go to PENDING.
- PENDING: data_ready_o=0; data_valid_i is ignored.
  - Static mode (scan_en_i=0): commit shadow to display at the next edge, then return to IDLE. PENDING lasts exactly 1 cycle.
  - Scan mode: commit only on the edge where the scan index wraps from NUM_DIGITS-1 to 0. This is the frame boundary and prevents tearing.
  - If scan_en_i falls while in PENDING, commit at the next edge.
- seg_o is registered: a display-register change appears on seg_o 1 cycle after commit.

Leading-zero blanking:
- When enabled, digits from NUM_DIGITS-1 downward are forced OFF while their nibble is 0, stopping at the first nonzero digit.
- Digit 0 is never blanked.

Blink:
- The blink counter runs freely 0..BLINK_DIV-1. At the wrap it toggles the phase.
- While phase=1, every digit whose mask bit is set is forced OFF.
- Blink is applied after leading-zero blanking.

Scan:
- With scan_en_i=1, the scan counter runs 0..SCAN_DIV-1. At each wrap the index increments modulo NUM_DIGITS.
- scan_an_o has exactly the bit at the index ON; scan_seg_o equals the final segment value of that digit. Both are registered.
- With scan_en_i=0: scan counter and index held at 0, scan_an_o all OFF, scan_seg_o OFF.
- seg_o is valid in both modes.

Simultaneous events:
- If a commit and a blink toggle occur on the same edge, the new data is shown with the new phase.
- If data_valid_i and reset release occur in the same cycle, the update is accepted on the first edge after release.

Test Plan:
1. Reset, scan off, ACTIVE_LOW=1; send data 0x0000_12AF with lz=0, mask=0 -> data_ready_o low for 1 cycle; 2 cycles after accept, seg_o digits 0..7 = 0E,08,24,79,40,40,40,40.
2. Same data with lz=1 -> digits 4..7 = 7F (off), digits 0..3 unchanged; data 0 with lz=1 -> digit 0 = 40, all others 7F.
3. BLINK_DIV=4, mask=0x01, data 0x8 -> digit 0 alternates 00 / 7F every 4 cycles, starting ON after reset; other digits unaffected.
4. NUM_DIGITS=4, SCAN_DIV=3, scan on, data 0x1234 -> scan_an_o cycles E,D,B,7 (3 cycles each); scan_seg_o follows 19,30,24,79.
5. Scan mode mid-frame: send 0x5678 while index=1 -> ready stays low until the index wraps 3->0; no frame mixes old and new digits; ready returns to 1 after commit.
6. Assert rst_ni while PENDING -> outputs go OFF immediately (asynchronous); after release, data_ready_o=1 and the old shadow is never displayed.
